// File: rtl/lamp_spi_frame_rx.sv
// lamp_spi_frame_rx -- SPI-slave frame receiver for the lamp controller.
//
// Oversamples the asynchronous SPI pins in the i_clk domain. It supports all
// four SPI modes (c_cpol/c_cpha) and MSB- or LSB-first bit order. It emits each
// completed word with its index. When chip-select releases, it reports whether
// the frame had the expected length. A chip-select timeout aborts a frame whose
// host stalls.
//
// Ports:
//   i_clk    system clock (at least 8x the SPI clock)
//   i_rst_n  asynchronous active-low reset
//   i_dck    SPI clock, asynchronous
//   i_cs     SPI chip select, active low, asynchronous
//   i_mosi   SPI data, asynchronous
//   o_data   last completed word (holds between strobes)
//   o_index  0-based word index of o_data
//   o_valid  one-cycle strobe, o_data/o_index are new
//   o_frame  one-cycle strobe, a correct frame ended
//   o_err    one-cycle strobe, a bad frame ended or the frame timed out
//   o_busy   high while a frame is in progress
module lamp_spi_frame_rx #(
    parameter int unsigned c_freq        = 20000000,
    parameter int unsigned c_word_bits   = 16,
    parameter int unsigned c_frame_words = 8,
    parameter bit          c_cpol        = 1'b0,
    parameter bit          c_cpha        = 1'b0,
    parameter bit          c_msb_first   = 1'b1,
    parameter int unsigned c_timeout_us  = 1000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_dck,
    input  logic                   i_cs,
    input  logic                   i_mosi,
    output logic [c_word_bits-1:0] o_data,
    output logic [7:0]             o_index,
    output logic                   o_valid,
    output logic                   o_frame,
    output logic                   o_err,
    output logic                   o_busy
);

    localparam int unsigned TMO_CYC  = c_freq / 1000000 * c_timeout_us;
    localparam int unsigned TMO_LAST = (TMO_CYC == 0) ? 0 : TMO_CYC - 1;
    localparam int unsigned BCW      = $clog2(c_word_bits);
    localparam logic [BCW-1:0] BC_LAST = BCW'(c_word_bits - 1);
    localparam logic [8:0]     FW      = 9'(c_frame_words);
    // Synchroniser bit order is {cs, dck, mosi}.
    localparam logic [2:0]     SYNC_RST = {1'b1, c_cpol, 1'b0};

    typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_ABORT} state_t;

    // ---------------------------------------------------------------- sync
    logic [2:0] s1_q, s2_q;
    logic [1:0] h_q;            // history for cs and dck only

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q <= SYNC_RST;
            s2_q <= SYNC_RST;
            h_q  <= SYNC_RST[2:1];
        end else begin
            s1_q <= {i_cs, i_dck, i_mosi};
            s2_q <= s1_q;
            h_q  <= s2_q[2:1];
        end
    end

    logic cs_fall, cs_rise, dck_lead, dck_trail, samp, mosi_s;
    assign cs_fall   =  h_q[1] & ~s2_q[2];
    assign cs_rise   = ~h_q[1] &  s2_q[2];
    assign dck_lead  = (h_q[0] == c_cpol) && (s2_q[1] != c_cpol);
    assign dck_trail = (h_q[0] != c_cpol) && (s2_q[1] == c_cpol);
    assign samp      = c_cpha ? dck_trail : dck_lead;
    assign mosi_s    = s2_q[0];

    // ---------------------------------------------------------------- FSM
    state_t                 state_q;
    logic [BCW-1:0]         bcnt_q;
    logic [8:0]             wcnt_q;     // one bit wider so a 256-word frame can be counted
    logic                   ovr_q;
    logic [31:0]            tmo_q;
    logic [c_word_bits-1:0] shreg_q, shreg_d;
    logic [7:0]             widx_q;
    logic                   wdone_q, fin_ok_q, fin_err_q, o_busy_q;
    logic                   tmo_hit;

    assign shreg_d = c_msb_first ? {shreg_q[c_word_bits-2:0], mosi_s}
                                 : {mosi_s, shreg_q[c_word_bits-1:1]};
    assign tmo_hit = (TMO_CYC != 0) && (tmo_q == TMO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            bcnt_q    <= '0;
            wcnt_q    <= '0;
            ovr_q     <= 1'b0;
            tmo_q     <= '0;
            shreg_q   <= '0;
            widx_q    <= '0;
            wdone_q   <= 1'b0;
            fin_ok_q  <= 1'b0;
            fin_err_q <= 1'b0;
            o_busy_q  <= 1'b0;
        end else begin
            wdone_q   <= 1'b0;
            fin_ok_q  <= 1'b0;
            fin_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q  <= ST_RX;
                        bcnt_q   <= '0;
                        wcnt_q   <= '0;
                        ovr_q    <= 1'b0;
                        tmo_q    <= '0;
                        o_busy_q <= 1'b1;
                    end
                end
                ST_RX: begin
                    // cs release outranks a coincident sampling edge
                    if (cs_rise) begin
                        state_q  <= ST_IDLE;
                        o_busy_q <= 1'b0;
                        if (bcnt_q == '0 && wcnt_q == FW && !ovr_q) fin_ok_q <= 1'b1;
                        else                                       fin_err_q <= 1'b1;
                    end else if (samp) begin
                        shreg_q <= shreg_d;
                        tmo_q   <= '0;
                        if (bcnt_q == BC_LAST) begin
                            bcnt_q <= '0;
                            if (wcnt_q < FW) begin
                                wdone_q <= 1'b1;
                                widx_q  <= wcnt_q[7:0];
                            end else begin
                                ovr_q <= 1'b1;
                            end
                            if (wcnt_q != 9'h1FF) wcnt_q <= wcnt_q + 9'd1;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        fin_err_q <= 1'b1;
                        state_q   <= ST_ABORT;
                    end else if (TMO_CYC != 0) begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                ST_ABORT: begin
                    // error already reported; just wait for the host to let go
                    if (cs_rise) begin
                        state_q  <= ST_IDLE;
                        o_busy_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    // Extra register stage: strobes appear one cycle after the FSM acts.
    logic [c_word_bits-1:0] o_data_q;
    logic [7:0]             o_index_q;
    logic                   o_valid_q, o_frame_q, o_err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_q  <= '0;
            o_index_q <= '0;
            o_valid_q <= 1'b0;
            o_frame_q <= 1'b0;
            o_err_q   <= 1'b0;
        end else begin
            o_valid_q <= wdone_q;
            o_frame_q <= fin_ok_q;
            o_err_q   <= fin_err_q;
            if (wdone_q) begin
                o_data_q  <= shreg_q;
                o_index_q <= widx_q;
            end
        end
    end

    assign o_data  = o_data_q;
    assign o_index = o_index_q;
    assign o_valid = o_valid_q;
    assign o_frame = o_frame_q;
    assign o_err   = o_err_q;
    assign o_busy  = o_busy_q;

endmodule
